// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and the data memory (slave).
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: word loads/stores over a req/ack bus, stalling upstream until the
// access completes and presenting bubbles to the enable-less MEM/WB register meanwhile.
module mem_stage #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mvalid,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [4:0]  mdestReg,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  mem_stage_if.master dmem,
  output logic        stall,
  output logic        wwreg_n,
  output logic        wm2reg_n,
  output logic [4:0]  wdest_n,
  output logic [31:0] wr_n,
  output logic [31:0] wdo_n,
  output logic        mem_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [7:0] LimitM1 = 8'(WAIT_LIMIT - 1);

  state_e      r_state;
  state_e      w_state_d;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wreg;
  logic        r_m2reg;
  logic [4:0]  r_dest;
  logic [31:0] r_rdata;
  logic        r_abort;
  logic [7:0]  r_cnt;

  logic w_mem_op;
  logic w_misaligned;
  logic w_start;
  logic w_limit;

  assign w_mem_op     = mvalid & (mm2reg | mwmem);
  assign w_misaligned = (malu[1:0] != 2'b00);
  assign w_start      = w_mem_op & ~w_misaligned;
  // Counter holds the number of completed unacknowledged BUSY cycles.
  assign w_limit      = (r_cnt == LimitM1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_start) w_state_d = StBusy;
      StBusy:  if (dmem.dmem_ack || w_limit) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wreg  <= 1'b0;
      r_m2reg <= 1'b0;
      r_dest  <= '0;
      r_rdata <= '0;
      r_abort <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_req   <= 1'b1;
            r_we    <= mwmem & ~mm2reg;
            r_addr  <= malu;
            r_wdata <= mb;
            r_wreg  <= mwreg;
            r_m2reg <= mm2reg;
            r_dest  <= mdestReg;
            r_rdata <= '0;
            r_abort <= 1'b0;
            r_cnt   <= '0;
          end
        end
        StBusy: begin
          if (dmem.dmem_ack) begin
            r_req   <= 1'b0;
            r_rdata <= r_m2reg ? dmem.dmem_rdata : 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
            if (w_limit) begin
              r_req   <= 1'b0;
              r_abort <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.dmem_req   = r_req;
  assign dmem.dmem_we    = r_we;
  assign dmem.dmem_addr  = r_addr;
  assign dmem.dmem_wdata = r_wdata;

  // Outputs default to a bubble; reset forces everything low regardless of state.
  always_comb begin
    stall    = 1'b0;
    wwreg_n  = 1'b0;
    wm2reg_n = 1'b0;
    wdest_n  = '0;
    wr_n     = '0;
    wdo_n    = '0;
    mem_err  = 1'b0;
    if (resetn) begin
      case (r_state)
        StIdle: begin
          if (!w_mem_op) begin
            wwreg_n = mwreg & mvalid;
            wdest_n = mdestReg;
            wr_n    = malu;
          end else if (w_misaligned) begin
            mem_err = 1'b1;
          end else begin
            stall = 1'b1;
          end
        end
        StBusy: stall = 1'b1;
        StDone: begin
          if (r_abort) begin
            mem_err = 1'b1;
          end else begin
            wwreg_n  = r_wreg;
            wm2reg_n = r_m2reg;
            wdest_n  = r_dest;
            wr_n     = r_addr;
            wdo_n    = r_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected results are queued at issue and compared when
// the stage presents a non-stalled result; a bench-driven memory model supplies ack/rdata.
module tb_mem_stage;

  localparam int unsigned WL = 4;

  logic        clock;
  logic        resetn;
  logic        mvalid;
  logic        mwreg;
  logic        mm2reg;
  logic        mwmem;
  logic [4:0]  mdestReg;
  logic [31:0] malu;
  logic [31:0] mb;
  logic        stall;
  logic        wwreg_n;
  logic        wm2reg_n;
  logic [4:0]  wdest_n;
  logic [31:0] wr_n;
  logic [31:0] wdo_n;
  logic        mem_err;

  mem_stage_if dmem_bus ();

  mem_stage #(
    .WAIT_LIMIT (WL)
  ) u_dut (
    .clock    (clock),
    .resetn   (resetn),
    .mvalid   (mvalid),
    .mwreg    (mwreg),
    .mm2reg   (mm2reg),
    .mwmem    (mwmem),
    .mdestReg (mdestReg),
    .malu     (malu),
    .mb       (mb),
    .dmem     (dmem_bus.master),
    .stall    (stall),
    .wwreg_n  (wwreg_n),
    .wm2reg_n (wm2reg_n),
    .wdest_n  (wdest_n),
    .wr_n     (wr_n),
    .wdo_n    (wdo_n),
    .mem_err  (mem_err)
  );

  typedef struct {
    logic        wwreg;
    logic        wm2reg;
    logic [4:0]  dest;
    logic [31:0] wr;
    logic [31:0] wdo;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_ctl"}, {29'd0, wwreg_n, wm2reg_n, mem_err}, 32'd0);
    check({tag, "_dest"}, {27'd0, wdest_n}, 32'd0);
    check({tag, "_wr"}, wr_n, 32'd0);
    check({tag, "_wdo"}, wdo_n, 32'd0);
    check({tag, "_bus"}, {30'd0, dmem_bus.dmem_req, dmem_bus.dmem_we}, 32'd0);
    check({tag, "_addr"}, dmem_bus.dmem_addr, 32'd0);
    check({tag, "_wdata"}, dmem_bus.dmem_wdata, 32'd0);
  endtask

  // Issue one instruction; ack_dly is the 0-based BUSY cycle carrying ack (-1: never).
  task automatic do_op(input logic v, input logic wr, input logic ld, input logic st,
                       input logic [4:0] d, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] rdata, input int ack_dly);
    exp_t e;
    int   exp_stall;
    int   n_stall;
    bit   done;
    logic mem;
    mvalid   = v;
    mwreg    = wr;
    mm2reg   = ld;
    mwmem    = st;
    mdestReg = d;
    malu     = a;
    mb       = b;
    dmem_bus.dmem_ack = 1'b0;
    mem = v & (ld | st);
    e = '{wwreg: 1'b0, wm2reg: 1'b0, dest: 5'd0, wr: 32'd0, wdo: 32'd0, err: 1'b0};
    if (!mem) begin
      e.wwreg = v & wr;
      e.dest  = d;
      e.wr    = a;
      exp_stall = 0;
    end else if (a[1:0] != 2'b00) begin
      e.err = 1'b1;
      exp_stall = 0;
    end else if (ack_dly >= 0 && ack_dly < int'(WL)) begin
      e.wwreg  = wr;
      e.wm2reg = ld;
      e.dest   = d;
      e.wr     = a;
      e.wdo    = ld ? rdata : 32'd0;
      exp_stall = ack_dly + 2;
    end else begin
      e.err = 1'b1;
      exp_stall = int'(WL) + 1;
    end
    sb.push_back(e);
    n_stall = 0;
    done    = 0;
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clock);
      if (stall) begin
        check("bubble", {29'd0, wwreg_n, wm2reg_n, mem_err}, 32'd0);
        if (n_stall > 0) begin
          check("req_busy", {31'd0, dmem_bus.dmem_req}, 32'd1);
          check("addr", dmem_bus.dmem_addr, a);
          check("we", {31'd0, dmem_bus.dmem_we}, {31'd0, st & ~ld});
          check("wdata", dmem_bus.dmem_wdata, b);
        end else begin
          check("req_idle", {31'd0, dmem_bus.dmem_req}, 32'd0);
        end
        n_stall++;
        dmem_bus.dmem_ack = (n_stall >= 2 && ack_dly >= 0 && (n_stall - 2) == ack_dly);
        dmem_bus.dmem_rdata = dmem_bus.dmem_ack ? rdata : 32'h5555_5555;
      end else begin
        if (sb.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          exp_t g;
          g = sb.pop_front();
          check("wwreg", {31'd0, wwreg_n}, {31'd0, g.wwreg});
          check("wm2reg", {31'd0, wm2reg_n}, {31'd0, g.wm2reg});
          check("dest", {27'd0, wdest_n}, {27'd0, g.dest});
          check("wr", wr_n, g.wr);
          check("wdo", wdo_n, g.wdo);
          check("mem_err", {31'd0, mem_err}, {31'd0, g.err});
          check("req_out", {31'd0, dmem_bus.dmem_req}, 32'd0);
        end
        done = 1;
      end
      @(posedge clock);
      #1;
      dmem_bus.dmem_ack = 1'b0;
    end
    if (!done) begin
      check("op_timeout", 32'd0, 32'd1);
      sb.delete();
    end
    check("stall_cycles", n_stall, exp_stall);
  endtask

  initial begin
    logic [31:0] rnd;
    resetn   = 1'b0;
    mvalid   = 1'b1;
    mwreg    = 1'b1;
    mm2reg   = 1'b0;
    mwmem    = 1'b0;
    mdestReg = 5'd5;
    malu     = 32'h1234;
    mb       = 32'd0;
    dmem_bus.dmem_ack   = 1'b0;
    dmem_bus.dmem_rdata = 32'd0;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    do_op(1, 1, 0, 0, 5'd5, 32'h1234, 32'd0, 32'd0, -1);
    do_op(0, 1, 1, 0, 5'd7, 32'h55, 32'd0, 32'd0, -1);
    do_op(1, 1, 1, 0, 5'd8, 32'h40, 32'd0, 32'hDEADBEEF, 0);
    do_op(1, 0, 0, 1, 5'd3, 32'h80, 32'hA5A5A5A5, 32'h1111, 3);
    do_op(1, 1, 1, 0, 5'd9, 32'h100, 32'd0, 32'h2222, -1);
    do_op(1, 1, 0, 0, 5'd11, 32'hABCD, 32'd0, 32'd0, -1);
    do_op(1, 1, 1, 0, 5'd10, 32'h104, 32'd0, 32'hCAFEF00D, 3);
    do_op(1, 1, 1, 0, 5'd4, 32'h42, 32'd0, 32'h3333, 0);
    do_op(1, 0, 0, 1, 5'd2, 32'h81, 32'h99, 32'd0, 0);
    do_op(1, 1, 1, 1, 5'd12, 32'h200, 32'h77, 32'h12345678, 1);

    // Stray ack while idle must not start or alter anything.
    mvalid = 1'b0;
    dmem_bus.dmem_ack = 1'b1;
    @(posedge clock);
    #1;
    dmem_bus.dmem_ack = 1'b0;
    @(negedge clock);
    check("stray_ack_req", {30'd0, dmem_bus.dmem_req, stall}, 32'd0);
    @(posedge clock);
    #1;

    for (int i = 0; i < 8; i++) begin
      rnd = $urandom();
      case (rnd[1:0])
        2'd0: do_op(1, rnd[2], 0, 0, rnd[7:3], rnd, 32'd0, 32'd0, -1);
        2'd1: do_op(1, 1, 1, 0, rnd[7:3], {rnd[31:2], 2'b00}, 32'd0, ~rnd,
                    int'($urandom_range(0, 5)));
        2'd2: do_op(1, 0, 0, 1, rnd[7:3], {rnd[31:2], 2'b00}, ~rnd, 32'd0,
                    int'($urandom_range(0, 5)));
        default: do_op(1, 1, 1, 0, rnd[7:3], {rnd[31:2], 2'b10}, 32'd0, 32'd0, 0);
      endcase
    end

    // Reset in the middle of an access, then a late ack.
    mvalid   = 1'b1;
    mwreg    = 1'b1;
    mm2reg   = 1'b1;
    mwmem    = 1'b0;
    mdestReg = 5'd6;
    malu     = 32'h300;
    @(posedge clock);
    #1;
    @(posedge clock);
    #1;
    check("pre_reset_req", {31'd0, dmem_bus.dmem_req}, 32'd1);
    @(negedge clock);
    #1;
    resetn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clock);
    resetn = 1'b1;
    mvalid = 1'b0;
    @(posedge clock);
    #1;
    dmem_bus.dmem_ack   = 1'b1;
    dmem_bus.dmem_rdata = 32'hBADBAD00;
    @(posedge clock);
    #1;
    dmem_bus.dmem_ack = 1'b0;
    @(negedge clock);
    check("late_ack", {29'd0, dmem_bus.dmem_req, stall, mem_err}, 32'd0);
    @(posedge clock);
    #1;
    do_op(1, 1, 0, 0, 5'd13, 32'h5678, 32'd0, 32'd0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
